// File: rtl/nrisc_pkg.sv
// Shared constants for the NRISC core: datapath widths and stack operation encoding.
package nrisc_pkg;

    localparam int NRISC_TAM    = 16;
    localparam int NRISC_FLAG_W = 3;

    typedef enum logic [1:0] {
        STK_IDLE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_REPL = 2'b11
    } stk_op_e;

endpackage

// File: rtl/nrisc_stack_mem.sv
// Stack storage: DEPTH x W register array, one synchronous write port, one asynchronous read port.
module nrisc_stack_mem #(
    parameter int W     = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Contents are deliberately not reset; entries above the pointer are never observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/nrisc_stack.sv
// Return-address/flag LIFO for the NRISC core with sticky overflow/underflow status.
// Flag storage per entry is built only when NRISC_STACK_FLAGS_EN is defined.
module nrisc_stack
    import nrisc_pkg::*;
#(
    parameter int TAM    = NRISC_TAM,
    parameter int DEPTH  = 8,
    parameter int FLAG_W = NRISC_FLAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 STACK_ctrl,
    input  logic [TAM-1:0]             STACK_PC_in,
    input  logic [FLAG_W-1:0]          STACK_FLAGS_in,
    output logic [TAM-1:0]             STACK_OUT,
    output logic [FLAG_W-1:0]          STACK_FLAGS,
    output logic [$clog2(DEPTH+1)-1:0] STACK_count,
    output logic                       STACK_full,
    output logic                       STACK_empty,
    output logic                       STACK_ovf,
    output logic                       STACK_unf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

`ifdef NRISC_STACK_FLAGS_EN
    localparam int MEM_W = TAM + FLAG_W;
`else
    localparam int MEM_W = TAM;
`endif

    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full, empty;
    logic [AW-1:0]    top_idx, push_idx;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [MEM_W-1:0] wr_data;
    logic [MEM_W-1:0] rd_data;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign top_idx  = AW'(count_q - CW'(1));
    assign push_idx = AW'(count_q);

`ifdef NRISC_STACK_FLAGS_EN
    assign wr_data = {STACK_PC_in, STACK_FLAGS_in};
`else
    assign wr_data = STACK_PC_in;
    logic unused_flags_in;
    assign unused_flags_in = ^STACK_FLAGS_in;
`endif

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_addr = top_idx;
        unique case (stk_op_e'(STACK_ctrl))
            STK_PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = push_idx;
                    count_d = count_q + CW'(1);
                end
            end
            STK_POP: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            STK_REPL: begin
                // Replace on an empty stack degrades to a push so ret-then-call never loses the address.
                wr_en = 1'b1;
                if (empty) begin
                    wr_addr = push_idx;
                    count_d = count_q + CW'(1);
                end
            end
            default: ;
        endcase
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    nrisc_stack_mem #(
        .W     (MEM_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (top_idx),
        .rd_data (rd_data)
    );

`ifdef NRISC_STACK_FLAGS_EN
    assign STACK_OUT   = empty ? '0 : rd_data[MEM_W-1:FLAG_W];
    assign STACK_FLAGS = empty ? '0 : rd_data[FLAG_W-1:0];
`else
    assign STACK_OUT   = empty ? '0 : rd_data;
    assign STACK_FLAGS = '0;
`endif

    assign STACK_count = count_q;
    assign STACK_full  = full;
    assign STACK_empty = empty;
    assign STACK_ovf   = ovf_q;
    assign STACK_unf   = unf_q;

endmodule
